ad9866_spi_sequencer: RTL and testbench

Owns the AD9866 control pins: SPI clock/data/enable and the chip reset. After reset it runs a power-up sequence, then writes a parameterised table of AD9866 registers. After that it serves single-register read/write commands from the core over a valid/ready handshake. It sits between the core's control-register decode and the ad9866_sclk/sdio/sdo/sen_n/rst_n pads.

---
 rtl/ad9866_spi_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_ad9866_spi_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9866_spi_sequencer.sv
// AD9866 control-pin owner: chip reset, power-up init table, then host single-register SPI access.
// Frames are 34*CLK_DIV cycles; cmd_ready is high only in IDLE, so host commands wait out reset/init/frames.
module ad9866_spi_sequencer #(
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 256,
  parameter int INIT_LEN   = 3,
  parameter logic [13*((INIT_LEN > 0) ? INIT_LEN : 1)-1:0] INIT_TABLE = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic [4:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       init_done,
  output logic       ad9866_sclk,
  output logic       ad9866_sdio,
  input  logic       ad9866_sdo,
  output logic       ad9866_sen_n,
  output logic       ad9866_rst_n
);

  localparam int CNT_MAX = (RST_CYCLES > 2*CLK_DIV) ? RST_CYCLES : 2*CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (INIT_LEN > 0) ? $clog2(INIT_LEN + 1) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2*CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(INIT_LEN);

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_RST_WAIT,
    S_INIT,
    S_SHIFT,
    S_GAP,
    S_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       hcnt_q, hcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      frame_q, frame_d;
  logic [7:0]       rx_q, rx_d;
  logic             host_q, host_d;
  logic             rnw_q, rnw_d;
  logic             sclk_q, sclk_d;
  logic             sdio_q, sdio_d;
  logic             sen_n_q, sen_n_d;
  logic             rst_n_q, rst_n_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             init_done_q, init_done_d;

  int          tbl_idx;
  logic [12:0] entry;
  logic        start;
  logic [15:0] start_dat;

  // idx_q points at the next entry to send, so it reaches INIT_LEN once the table is exhausted.
  always_comb begin
    tbl_idx = (int'(idx_q) < INIT_LEN) ? int'(idx_q) : 0;
    entry   = INIT_TABLE[13*tbl_idx +: 13];
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    rx_d        = rx_q;
    host_d      = host_q;
    rnw_d       = rnw_q;
    sclk_d      = sclk_q;
    sdio_d      = sdio_q;
    sen_n_d     = sen_n_q;
    rst_n_d     = rst_n_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done_q;
    start       = 1'b0;
    start_dat   = {3'b000, entry};

    case (state_q)
      S_RST_HOLD: begin
        rst_n_d = 1'b0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          rst_n_d = 1'b1;
          state_d = S_RST_WAIT;
        end
      end

      S_RST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RST_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          if (INIT_LEN == 0) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_INIT;
          end
        end
      end

      S_INIT: begin
        start  = 1'b1;
        host_d = 1'b0;
        idx_d  = idx_q + 1'b1;
      end

      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          hcnt_d = hcnt_q + 5'd1;
          if (!hcnt_q[0]) begin
            sclk_d = 1'b1;
            // Rising edges 8..15 carry the read data byte back from the chip.
            if (hcnt_q[4]) rx_d = {rx_q[6:0], ad9866_sdo};
          end else begin
            sclk_d  = 1'b0;
            sdio_d  = frame_q[14];
            frame_d = {frame_q[14:0], 1'b0};
            if (hcnt_q == 5'd31) begin
              hcnt_d  = '0;
              sen_n_d = 1'b1;
              sdio_d  = 1'b0;
              state_d = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (host_q) begin
            rsp_valid_d = 1'b1;
            if (rnw_q) rsp_rdata_d = rx_q;
            state_d = S_IDLE;
          end else if (idx_q == IDX_END) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            // Chain straight into the next entry to keep the 34*CLK_DIV frame period.
            start = 1'b1;
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          start     = 1'b1;
          host_d    = 1'b1;
          rnw_d     = cmd_rnw;
          start_dat = {cmd_rnw, 2'b00, cmd_addr, (cmd_rnw ? 8'h00 : cmd_wdata)};
        end
      end

      default: begin
        state_d = S_RST_HOLD;
        cnt_d   = '0;
      end
    endcase

    if (start) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      hcnt_d  = '0;
      frame_d = start_dat;
      sdio_d  = start_dat[15];
      sclk_d  = 1'b0;
      sen_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RST_HOLD;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      idx_q       <= '0;
      frame_q     <= '0;
      rx_q        <= '0;
      host_q      <= 1'b0;
      rnw_q       <= 1'b0;
      sclk_q      <= 1'b0;
      sdio_q      <= 1'b0;
      sen_n_q     <= 1'b1;
      rst_n_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      rx_q        <= rx_d;
      host_q      <= host_d;
      rnw_q       <= rnw_d;
      sclk_q      <= sclk_d;
      sdio_q      <= sdio_d;
      sen_n_q     <= sen_n_d;
      rst_n_q     <= rst_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign init_done    = init_done_q;
  assign ad9866_sclk  = sclk_q;
  assign ad9866_sdio  = sdio_q;
  assign ad9866_sen_n = sen_n_q;
  assign ad9866_rst_n = rst_n_q;

endmodule

// File: tb/tb_ad9866_spi_sequencer.sv
// Directed bench: dut 0 = bare reset timing, dut 1 = two-entry init table, dut 2 = host read/write at CLK_DIV=4.
module tb_ad9866_spi_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       c_valid [3];
  logic       c_rnw   [3];
  logic [4:0] c_addr  [3];
  logic [7:0] c_wdata [3];
  logic       sdo     [3];
  logic       o_ready [3];
  logic       o_rsp   [3];
  logic [7:0] o_rdata [3];
  logic       o_done  [3];
  logic       o_sclk  [3];
  logic       o_sdio  [3];
  logic       o_sen_n [3];
  logic       o_rst_n [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ad9866_spi_sequencer #(.CLK_DIV(2), .RST_CYCLES(16), .INIT_LEN(0)) u_a (
    .clk(clk), .rst(rst),
    .cmd_valid(c_valid[0]), .cmd_ready(o_ready[0]), .cmd_rnw(c_rnw[0]),
    .cmd_addr(c_addr[0]), .cmd_wdata(c_wdata[0]),
    .rsp_valid(o_rsp[0]), .rsp_rdata(o_rdata[0]), .init_done(o_done[0]),
    .ad9866_sclk(o_sclk[0]), .ad9866_sdio(o_sdio[0]), .ad9866_sdo(sdo[0]),
    .ad9866_sen_n(o_sen_n[0]), .ad9866_rst_n(o_rst_n[0])
  );

  ad9866_spi_sequencer #(.CLK_DIV(2), .RST_CYCLES(16), .INIT_LEN(2),
                         .INIT_TABLE({13'h0_A5, 13'h1F_3C})) u_b (
    .clk(clk), .rst(rst),
    .cmd_valid(c_valid[1]), .cmd_ready(o_ready[1]), .cmd_rnw(c_rnw[1]),
    .cmd_addr(c_addr[1]), .cmd_wdata(c_wdata[1]),
    .rsp_valid(o_rsp[1]), .rsp_rdata(o_rdata[1]), .init_done(o_done[1]),
    .ad9866_sclk(o_sclk[1]), .ad9866_sdio(o_sdio[1]), .ad9866_sdo(sdo[1]),
    .ad9866_sen_n(o_sen_n[1]), .ad9866_rst_n(o_rst_n[1])
  );

  ad9866_spi_sequencer #(.CLK_DIV(4), .RST_CYCLES(16), .INIT_LEN(0)) u_c (
    .clk(clk), .rst(rst),
    .cmd_valid(c_valid[2]), .cmd_ready(o_ready[2]), .cmd_rnw(c_rnw[2]),
    .cmd_addr(c_addr[2]), .cmd_wdata(c_wdata[2]),
    .rsp_valid(o_rsp[2]), .rsp_rdata(o_rdata[2]), .init_done(o_done[2]),
    .ad9866_sclk(o_sclk[2]), .ad9866_sdio(o_sdio[2]), .ad9866_sdo(sdo[2]),
    .ad9866_sen_n(o_sen_n[2]), .ad9866_rst_n(o_rst_n[2])
  );

  // Chip-side view of each SPI port: sdio is shifted in on every SCLK rise while sen_n is low.
  logic [15:0] mon_sh    [3] = '{default: '0};
  int          mon_rises [3] = '{default: 0};
  logic [15:0] fr_dat    [3][8];
  int          fr_rises  [3][8];
  int          fr_n      [3] = '{default: 0};
  int          sen_falls [3] = '{default: 0};
  logic        p_sclk    [3] = '{default: 1'b0};
  logic        p_sen     [3] = '{default: 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (p_sen[i] && !o_sen_n[i]) begin
        mon_sh[i]    = '0;
        mon_rises[i] = 0;
        sen_falls[i]++;
      end
      if (!p_sclk[i] && o_sclk[i] && !o_sen_n[i]) begin
        mon_sh[i] = {mon_sh[i][14:0], o_sdio[i]};
        mon_rises[i]++;
      end
      if (!p_sen[i] && o_sen_n[i] && fr_n[i] < 8) begin
        fr_dat[i][fr_n[i]]   = mon_sh[i];
        fr_rises[i][fr_n[i]] = mon_rises[i];
        fr_n[i]++;
      end
      p_sen[i]  = o_sen_n[i];
      p_sclk[i] = o_sclk[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic proc_a();
    int n;
    n = 0;
    while (!o_rst_n[0] && n < 1000) begin n++; @(negedge clk); end
    check("a_rst_n_low_cycles", n, 16);
    n = 0;
    while (!o_done[0] && n < 1000) begin n++; @(negedge clk); end
    check("a_post_release_wait", n, 16);
    check("a_ready_with_done", 32'(o_ready[0]), 32'h1);
  endtask

  // Command held valid from reset release; it must only be taken on the first IDLE cycle.
  task automatic proc_b();
    int fall_t [4];
    int nf, t_done, t_rdy, rdy_after, early_rdy, rsp_n, early_rsp;
    logic prev;
    for (int k = 0; k < 4; k++) fall_t[k] = -1000;
    nf = 0; t_done = -1; t_rdy = -1; rdy_after = -1;
    early_rdy = 0; rsp_n = 0; early_rsp = 0; prev = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (prev && !o_sen_n[1] && nf < 4) begin fall_t[nf] = t; nf++; end
      if (o_done[1] && t_done < 0) t_done = t;
      if (o_ready[1] && !o_done[1]) early_rdy++;
      if (o_ready[1] && t_rdy < 0) t_rdy = t;
      if (t_rdy >= 0 && t == t_rdy + 1) begin
        rdy_after  = 32'(o_ready[1]);
        c_valid[1] = 1'b0;
      end
      if (o_rsp[1]) begin
        rsp_n++;
        if (t_done < 0) early_rsp++;
      end
      prev = o_sen_n[1];
      @(negedge clk);
    end
    check("b_frame_count", nf, 3);
    check("b_init_frame_spacing", fall_t[1] - fall_t[0], 68);
    check("b_done_after_2nd_frame", t_done - fall_t[1], 68);
    check("b_ready_first_idle", t_rdy, t_done);
    check("b_ready_low_after_accept", rdy_after, 0);
    check("b_host_frame_next_cycle", fall_t[2] - t_rdy, 1);
    check("b_no_ready_before_done", early_rdy, 0);
    check("b_no_rsp_for_init", early_rsp, 0);
    check("b_single_rsp", rsp_n, 1);
  endtask

  task automatic host_cmd(input logic rnw, input logic [4:0] addr, input logic [7:0] wdata,
                          input logic [7:0] rd, output int lo_n, output int gap_n,
                          output int rsp_n, output logic [7:0] rsp_dat);
    int w, rise_n, t_rise;
    logic ps;
    logic [2:0] bi;
    w = 0;
    while (!o_ready[2] && w < 1000) begin w++; @(negedge clk); end
    check("c_ready_before_cmd", 32'(o_ready[2]), 32'h1);
    c_valid[2] = 1'b1; c_rnw[2] = rnw; c_addr[2] = addr; c_wdata[2] = wdata;
    @(negedge clk);
    c_valid[2] = 1'b0;
    lo_n = 0; gap_n = -1; rsp_n = 0; rsp_dat = 8'h00;
    rise_n = 0; t_rise = -1000; ps = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (!o_sen_n[2]) lo_n++;
      if (!ps && o_sclk[2] && !o_sen_n[2]) rise_n++;
      if (ps && !o_sclk[2] && rise_n >= 8 && rise_n <= 15) begin
        bi     = 3'(15 - rise_n);
        sdo[2] = rd[bi];
      end
      if (o_sen_n[2] && lo_n > 0 && t_rise < 0) t_rise = t;
      if (o_rsp[2]) begin
        rsp_n++;
        rsp_dat = o_rdata[2];
        gap_n   = t - t_rise;
      end
      ps = o_sclk[2];
      @(negedge clk);
    end
  endtask

  initial begin
    int lo, gp, rc, base, base_b, n, w, rsp_bad, lowc;
    logic [7:0] rdat;
    for (int i = 0; i < 3; i++) begin
      c_valid[i] = 1'b0; c_rnw[i] = 1'b0; c_addr[i] = '0; c_wdata[i] = '0; sdo[i] = 1'b0;
    end
    repeat (5) @(negedge clk);
    check("reset_pins", 32'({o_sclk[2], o_sdio[2], o_sen_n[2], o_rst_n[2],
                             o_ready[2], o_rsp[2], o_done[2]}), 32'h10);
    check("reset_rdata", 32'(o_rdata[2]), 32'h0);

    c_valid[1] = 1'b1; c_rnw[1] = 1'b0; c_addr[1] = 5'h05; c_wdata[1] = 8'h11;
    rst = 1'b0;
    fork
      proc_a();
      proc_b();
    join
    check("a_sen_never_fell", sen_falls[0], 0);
    check("b_frames_seen", fr_n[1], 3);
    check("b_frame0", 32'(fr_dat[1][0]), 32'h1F3C);
    check("b_frame1", 32'(fr_dat[1][1]), 32'h00A5);
    check("b_frame2_host", 32'(fr_dat[1][2]), 32'h0511);
    check("b_frame0_rises", fr_rises[1][0], 16);

    base = fr_n[2];
    host_cmd(1'b0, 5'h0A, 8'h5C, 8'h00, lo, gp, rc, rdat);
    check("wr_frame", 32'(fr_dat[2][base]), 32'h0A5C);
    check("wr_rises", fr_rises[2][base], 16);
    check("wr_sen_low", lo, 128);
    check("wr_rsp_after_sen_rise", gp, 8);
    check("wr_rsp_pulses", rc, 1);
    check("wr_rdata_held", 32'(rdat), 32'h00);

    base = fr_n[2];
    host_cmd(1'b1, 5'h13, 8'h6E, 8'hA7, lo, gp, rc, rdat);
    check("rd_frame", 32'(fr_dat[2][base]), 32'h9300);
    check("rd_sen_low", lo, 128);
    check("rd_rsp_pulses", rc, 1);
    check("rd_rdata", 32'(rdat), 32'hA7);

    base = fr_n[2];
    host_cmd(1'b0, 5'h02, 8'hFF, 8'h00, lo, gp, rc, rdat);
    check("wr2_frame", 32'(fr_dat[2][base]), 32'h02FF);
    check("wr2_rdata_held", 32'(rdat), 32'hA7);

    w = 0;
    while (!o_ready[2] && w < 1000) begin w++; @(negedge clk); end
    c_valid[2] = 1'b1; c_rnw[2] = 1'b0; c_addr[2] = 5'h1F; c_wdata[2] = 8'h81;
    @(negedge clk);
    c_valid[2] = 1'b0;
    n = 0; w = 0; rsp_bad = 0;
    while (n < 40 && w < 400) begin
      if (!o_sen_n[2]) n++;
      if (o_rsp[2]) rsp_bad++;
      w++;
      @(negedge clk);
    end
    check("abort_reached_cycle40", n, 40);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pins", 32'({o_sclk[2], o_sen_n[2], o_rst_n[2], o_ready[2],
                             o_rsp[2], o_done[2]}), 32'h10);
    repeat (3) begin
      if (o_rsp[2]) rsp_bad++;
      @(negedge clk);
    end
    base_b = fr_n[1];
    rst = 1'b0;
    lowc = 0;
    for (int t = 0; t < 300; t++) begin
      if (!o_rst_n[2]) lowc++;
      if (o_rsp[2]) rsp_bad++;
      @(negedge clk);
    end
    check("abort_rst_n_low", lowc, 16);
    check("abort_no_rsp", rsp_bad, 0);
    check("abort_c_done_again", 32'(o_done[2]), 32'h1);
    check("abort_b_reinit_frames", fr_n[1] - base_b, 2);
    check("abort_b_reinit_frame0", 32'(fr_dat[1][base_b]), 32'h1F3C);
    check("abort_b_done_again", 32'(o_done[1]), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
